sig_period_counter: RTL and testbench
=====================================

// Module: sig_period_counter
// PURPOSE
//  Measures RF sync input period: counts clk cycles spanning M_PERIODS rising edges of sig.
//  Sits directly upstream of the frequency->cap-state look-up table.
//  Publishes n_clk, a one-cycle n_valid strobe per completed window, and a no_sig flag.
//  Also drives the n_clk time-encoder and feeds driver settling logic via the LUT.
// PARAMETERS
//  N_WIDTH      14  width of n_clk; saturation/timeout value = 2^N_WIDTH-1
//  M_PERIODS    4   sig periods per measurement window (>=1, <=255)
//  SYNC_STAGES  2   flip-flops in sig synchroniser (>=2)
// PORTS
//  clk      in   1        system clock, all logic on posedge
//  rst_n    in   1        asynchronous, active-low reset
//  sig      in   1        RF-derived square wave, asynchronous to clk
//  n_clk    out  N_WIDTH  clk cycles per M_PERIODS sig periods, registered, saturating
//  n_valid  out  1        1-cycle strobe: n_clk updated this cycle
//  no_sig   out  1        1 = last window timed out (no/slow signal)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - n_clk=0, n_valid=0, no_sig=1.
//   - Synchroniser cleared; clk_cnt=0, per_cnt=0; state=IDLE.
//  Input path:
//   - sig passes through SYNC_STAGES FFs; s_d = last stage delayed 1 cycle.
//   - edge = sync_last & ~s_d, combinational, 1 cycle wide.
//   - sig rise sampled at clk k gives edge high in cycle k+SYNC_STAGES.
//  FSM, two states:
//   IDLE:
//    - clk_cnt and per_cnt held at 0.
//    - On edge -> COUNT, clk_cnt<=0, per_cnt<=0.
//   COUNT:
//    - clk_cnt increments by 1 every cycle.
//    - Edge with per_cnt<M_PERIODS-1: per_cnt++.
//    - Edge with per_cnt==M_PERIODS-1 closes the window:
//       n_clk<=clk_cnt+1, n_valid<=1, no_sig<=0, clk_cnt<=0, per_cnt<=0, stay COUNT.
//       The closing edge opens the next window; back-to-back windows have no dead time.
//    - clk_cnt==2^N_WIDTH-2 with no closing edge = timeout:
//       n_clk<=all ones, n_valid<=1, no_sig<=1, -> IDLE.
//       Timeout has priority over a simultaneous edge.
//  Timing and widths:
//   - n_valid registered; high exactly the cycle after the closing edge/timeout cycle.
//   - n_clk is stable between strobes.
//   - Rise-to-strobe latency = SYNC_STAGES+1 clk cycles.
//   - Steady sig period P cycles -> n_clk = M_PERIODS*P.
//   - clk_cnt is N_WIDTH bits and can never wrap, because the timeout fires first.
//   - Max reportable result = 2^N_WIDTH-2; all ones means saturated/no signal.
//  Boundary conditions:
//   - sig stuck high or low: first timeout after 2^N_WIDTH-1 cycles in COUNT.
//     Then IDLE indefinitely; no further strobes until an edge arrives.
//   - sig high for only 1 clk: still one edge, counted normally.
//   - sig faster than clk/2: aliased; out of spec, no protection required.
//   - rst_n asserted mid-window: window discarded, all outputs return to reset values.
//   - First window after reset or IDLE starts on first detected edge.
// TESTING
//  1. Reset with sig toggling, release; sig period 40 clk (20 hi/20 lo), M=4
//     -> first n_valid 4 windows' edges later; n_clk=160, no_sig=0.
//     Thereafter n_valid every 160 cycles.
//  2. Period change 40 -> 25 clk mid-window
//     -> one mixed window value between 100 and 160, then n_clk=100 every window.
//  3. Hold sig low after lock
//     -> exactly 16383 cycles after the last closing edge: n_valid, n_clk=16383, no_sig=1.
//     No further strobes; resume toggling -> normal n_clk one window later, no_sig=0.
//  4. Assert rst_n low mid-window (asynchronously, between clk edges)
//     -> outputs 0/0/1 immediately; no strobe from the partial window.
//  5. Sig rise aligned with clk edge, edge check
//     -> n_valid exactly SYNC_STAGES+1 cycles after the closing rise sample.
//  6. M_PERIODS=1, period 3 clk (minimal)
//     -> n_clk=3 every 3 cycles, n_valid never missed.

Source files
------------

// File: rtl/sig_period_counter.sv
// Counts clk cycles spanning M_PERIODS rising edges of an asynchronous sig; all-ones result means timeout/no signal.
// Latency: SYNC_STAGES+1 clk from the sig rise to the n_valid strobe; no backpressure, n_valid is a strobe with no ready.
module sig_period_counter #(
    parameter int N_WIDTH     = 14,
    parameter int M_PERIODS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sig,
    output logic [N_WIDTH-1:0] n_clk,
    output logic               n_valid,
    output logic               no_sig
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // clk_cnt stops one short of all ones so the saturated code can never be a real result
    localparam logic [N_WIDTH-1:0] CNT_LAST = {{(N_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [7:0]         PER_LAST = 8'(M_PERIODS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;
    logic                   sig_edge;

    state_t                 state_q;
    logic [N_WIDTH-1:0]     clk_cnt_q;
    logic [N_WIDTH-1:0]     clk_cnt_d;
    logic [7:0]             per_cnt_q;
    logic [N_WIDTH-1:0]     n_clk_q;
    logic                   n_valid_q;
    logic                   no_sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_edge  = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
    assign clk_cnt_d = clk_cnt_q + N_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            per_cnt_q <= '0;
            n_clk_q   <= '0;
            n_valid_q <= 1'b0;
            no_sig_q  <= 1'b1;
        end else begin
            n_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    per_cnt_q <= '0;
                    if (sig_edge) begin
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    // timeout wins over an edge landing in the same cycle
                    if (clk_cnt_q == CNT_LAST) begin
                        n_clk_q   <= '1;
                        n_valid_q <= 1'b1;
                        no_sig_q  <= 1'b1;
                        clk_cnt_q <= '0;
                        per_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (sig_edge && (per_cnt_q == PER_LAST)) begin
                        n_clk_q   <= clk_cnt_d;
                        n_valid_q <= 1'b1;
                        no_sig_q  <= 1'b0;
                        clk_cnt_q <= '0;
                        per_cnt_q <= '0;
                    end else begin
                        clk_cnt_q <= clk_cnt_d;
                        if (sig_edge) begin
                            per_cnt_q <= per_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign n_clk   = n_clk_q;
    assign n_valid = n_valid_q;
    assign no_sig  = no_sig_q;

endmodule

// File: tb/tb_sig_period_counter.sv
// Bench for sig_period_counter: M=4 instance driven from a period table with a scoreboard, plus an M=1 instance.
module tb_sig_period_counter;

    localparam int NW      = 14;
    localparam int M       = 4;
    localparam int SYNC    = 2;
    localparam int SAT     = (1 << NW) - 1;
    localparam int LAT     = SYNC + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig = 1'b0;
    logic          sig1 = 1'b0;
    logic [NW-1:0] n_clk, n_clk1;
    logic          n_valid, n_valid1;
    logic          no_sig, no_sig1;

    sig_period_counter #(.N_WIDTH(NW), .M_PERIODS(M), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .sig(sig),
        .n_clk(n_clk), .n_valid(n_valid), .no_sig(no_sig)
    );

    sig_period_counter #(.N_WIDTH(NW), .M_PERIODS(1), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .rst_n(rst_n), .sig(sig1),
        .n_clk(n_clk1), .n_valid(n_valid1), .no_sig(no_sig1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int n_clk;
        int no_sig;
        int cyc;
    } exp_t;
    exp_t sb[$];

    // window model at the level of sig rises, in drive-cycle units
    bit idle = 1'b1;
    int win_start = 0;
    int rise_cnt = 0;
    int last_nclk = -1;

    task automatic model_rise();
        exp_t e;
        if (idle) begin
            idle      = 1'b0;
            win_start = cyc;
            rise_cnt  = 0;
        end else begin
            rise_cnt++;
            if (rise_cnt == M) begin
                e.n_clk   = cyc - win_start;
                e.no_sig  = 0;
                e.cyc     = cyc + LAT;
                sb.push_back(e);
                win_start = cyc;
                rise_cnt  = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && n_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("n_clk", int'(n_clk), e.n_clk);
                chk("no_sig_at_strobe", int'(no_sig), e.no_sig);
                chk("strobe_cycle", cyc, e.cyc);
            end
            last_nclk = int'(n_clk);
        end
    end

    bit m1_en = 1'b0;
    int m1_cnt = 0;
    int m1_last = -1;
    always @(negedge clk) begin
        if (m1_en && n_valid1) begin
            chk("m1_n_clk", int'(n_clk1), 3);
            if (m1_last >= 0) chk("m1_interval", cyc - m1_last, 3);
            m1_last = cyc;
            m1_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_period(input int p, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            model_rise();
            sig = 1'b1;
            tick(hi);
            sig = 1'b0;
            tick(p - hi);
        end
    endtask

    typedef struct {
        int period;
        int hi;
        int rises;
        int exp_nclk;
    } vec_t;
    vec_t vecs[4];

    initial begin
        exp_t e;
        vecs[0] = '{period: 40, hi: 20, rises: 13, exp_nclk: 160};
        vecs[1] = '{period: 25, hi: 12, rises: 12, exp_nclk: 100};
        vecs[2] = '{period: 30, hi: 1,  rises: 12, exp_nclk: 120};
        vecs[3] = '{period: 37, hi: 18, rises: 12, exp_nclk: 148};

        // reset with sig toggling
        tick(1);
        for (int i = 0; i < 6; i++) begin
            sig = ~sig;
            tick(1);
        end
        sig = 1'b0;
        tick(3);
        chk("reset_n_clk", int'(n_clk), 0);
        chk("reset_n_valid", int'(n_valid), 0);
        chk("reset_no_sig", int'(no_sig), 1);
        rst_n = 1'b1;
        tick(4);
        chk("idle_no_sig", int'(no_sig), 1);

        for (int v = 0; v < 4; v++) begin
            drive_period(vecs[v].period, vecs[v].hi, vecs[v].rises);
            chk($sformatf("table_row%0d_n_clk", v), last_nclk, vecs[v].exp_nclk);
            chk($sformatf("table_row%0d_no_sig", v), int'(no_sig), 0);
        end

        // async reset in the middle of an open window
        drive_period(40, 20, 2);
        tick(7);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_n_clk", int'(n_clk), 0);
        chk("async_rst_n_valid", int'(n_valid), 0);
        chk("async_rst_no_sig", int'(no_sig), 1);
        tick(3);
        rst_n = 1'b1;
        idle = 1'b1;
        tick(50);

        // lock, then hold sig low until timeout
        drive_period(40, 20, 5);
        chk("relock_n_clk", last_nclk, 160);
        e.n_clk  = SAT;
        e.no_sig = 1;
        e.cyc    = win_start + SAT + LAT;
        sb.push_back(e);
        idle = 1'b1;

        // M=1, period 3, on the second instance while the first waits out its timeout
        m1_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sig1 = 1'b1;
            tick(1);
            sig1 = 1'b0;
            tick(2);
        end
        tick(LAT + 1);
        m1_en = 1'b0;
        chk("m1_strobe_count", m1_cnt, 19);

        tick(SAT + 200);
        chk("timeout_n_clk_held", int'(n_clk), SAT);
        chk("timeout_no_sig_held", int'(no_sig), 1);
        chk("timeout_pending", sb.size(), 0);
        tick(500);

        drive_period(40, 20, 5);
        chk("resume_n_clk", last_nclk, 160);
        chk("resume_no_sig", int'(no_sig), 0);
        tick(10);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
